lcd_fb_scanout: RTL and testbench

- Downstream consumer of the PPU wrapper's pixel stream: captures `pixel_out`/`lcd_addr`/`lcd_write` into a 160x144x2-bit LCD framebuffer.
- Independently scans that buffer out as 640x480 VGA-style timing, with integer upscaling, centring and shade-to-RGB mapping.
- Single clock domain; pixel rate set by a clock-enable.

---
 rtl/lcd_fb_scanout_if.sv | 22 ++
 rtl/lcd_fb_scanout.sv | 208 ++++++++++++++++++++
 tb/tb_lcd_fb_scanout.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_fb_scanout_if.sv
// PPU pixel write bus and VGA-style output bundle of lcd_fb_scanout.
interface lcd_fb_scanout_if;
    logic        lcd_write;
    logic [14:0] lcd_addr;
    logic [1:0]  pixel_out;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;
    logic        frame_start;

    modport master (
        output lcd_write, lcd_addr, pixel_out,
        input  vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start
    );

    modport slave (
        input  lcd_write, lcd_addr, pixel_out,
        output vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start
    );
endinterface

// File: rtl/lcd_fb_scanout.sv
// LCD framebuffer capture plus 640x480 upscaled scanout with a 2-tick read/palette pipeline.
// Optional macro LCD_FB_DMG_GREEN_EN selects the DMG green palette; grey palette otherwise.
module lcd_fb_scanout #(
    parameter int GB_W     = 160,
    parameter int GB_H     = 144,
    parameter int SCALE    = 3,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_TOTAL  = 800,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_TOTAL  = 525,
    parameter int X_OFF    = 80,
    parameter int Y_OFF    = 24
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pix_ce,
    lcd_fb_scanout_if.slave lcd
);
    localparam int FB_WORDS = GB_W * GB_H;
    localparam int AW       = $clog2(FB_WORDS);

    localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0]  V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0]  HS_BEG     = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  VS_BEG     = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  WX_BEG     = 10'(X_OFF);
    localparam logic [9:0]  WX_END     = 10'(X_OFF + GB_W * SCALE);
    localparam logic [9:0]  WX_LAST    = 10'(X_OFF + GB_W * SCALE - 1);
    localparam logic [9:0]  WY_BEG     = 10'(Y_OFF);
    localparam logic [9:0]  WY_END     = 10'(Y_OFF + GB_H * SCALE);
    localparam logic [1:0]  S_LAST     = 2'(SCALE - 1);
    localparam logic [7:0]  GB_H_C     = 8'(GB_H);
    localparam logic [14:0] FB_DEPTH   = 15'(FB_WORDS);
    localparam logic [14:0] LINE_STEP  = 15'(GB_W);
    localparam logic [11:0] BORDER_RGB = 12'h000;

    function automatic logic [11:0] shade_to_rgb(input logic [1:0] shade);
        logic [11:0] rgb;
`ifdef LCD_FB_DMG_GREEN_EN
        case (shade)
            2'd0:    rgb = 12'h9B0;
            2'd1:    rgb = 12'h8A0;
            2'd2:    rgb = 12'h363;
            2'd3:    rgb = 12'h030;
            default: rgb = 12'h000;
        endcase
`else
        case (shade)
            2'd0:    rgb = 12'hFFF;
            2'd1:    rgb = 12'hAAA;
            2'd2:    rgb = 12'h555;
            2'd3:    rgb = 12'h000;
            default: rgb = 12'h000;
        endcase
`endif
        return rgb;
    endfunction

    logic [1:0]  fb_mem [0:FB_WORDS-1];

    logic [9:0]  h_q, h_d, v_q, v_d;
    logic [1:0]  sx_q, sx_d, sy_q, sy_d;
    logic [7:0]  gb_x_q, gb_x_d, gb_y_q, gb_y_d;
    logic [14:0] line_base_q, line_base_d;
    logic [1:0]  rd_data_q;
    logic        win1_q, blank1_q, hs1_q, vs1_q;
    logic [11:0] rgb_q, rgb_d;
    logic        hs_q, vs_q;

    logic        in_win_s, blank_s, hs_raw_s, vs_raw_s, origin_s;
    logic        rd_en_s, wr_en_s;
    logic [14:0] rd_addr_s;

    // Raster-position decode from the undelayed counters.
    always_comb begin
        in_win_s  = (h_q >= WX_BEG) && (h_q < WX_END) && (v_q >= WY_BEG) && (v_q < WY_END);
        blank_s   = (h_q >= H_ACT) || (v_q >= V_ACT);
        hs_raw_s  = !((h_q >= HS_BEG) && (h_q < HS_END));
        vs_raw_s  = !((v_q >= VS_BEG) && (v_q < VS_END));
        origin_s  = (h_q == 10'd0) && (v_q == 10'd0);
        rd_addr_s = line_base_q + {7'd0, gb_x_q};
        rd_en_s   = pix_ce && in_win_s && (gb_y_q < GB_H_C) && (rd_addr_s < FB_DEPTH);
        wr_en_s   = lcd.lcd_write && (lcd.lcd_addr < FB_DEPTH);
    end

    // Raster counters and the add-only upscaling address walker, advanced by pix_ce.
    always_comb begin
        h_d         = h_q;
        v_d         = v_q;
        sx_d        = sx_q;
        gb_x_d      = gb_x_q;
        sy_d        = sy_q;
        gb_y_d      = gb_y_q;
        line_base_d = line_base_q;
        if (pix_ce) begin
            if (h_q == H_LAST) begin
                h_d = 10'd0;
                v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
            // Outside the window the row cursor sits at 0, so it is freshly loaded at h=X_OFF.
            if (in_win_s) begin
                if (sx_q == S_LAST) begin
                    sx_d   = 2'd0;
                    gb_x_d = gb_x_q + 8'd1;
                end else begin
                    sx_d = sx_q + 2'd1;
                end
            end else begin
                sx_d   = 2'd0;
                gb_x_d = 8'd0;
            end
            if (origin_s) begin
                sy_d        = 2'd0;
                gb_y_d      = 8'd0;
                line_base_d = 15'd0;
            end else if (in_win_s && (h_q == WX_LAST)) begin
                if (sy_q == S_LAST) begin
                    sy_d        = 2'd0;
                    gb_y_d      = gb_y_q + 8'd1;
                    line_base_d = line_base_q + LINE_STEP;
                end else begin
                    sy_d = sy_q + 2'd1;
                end
            end else begin
                sy_d = sy_q;
            end
        end else begin
            h_d = h_q;
        end
    end

    // Stage-2 colour select: blanking wins, then window palette, else border.
    always_comb begin
        rgb_d = 12'h000;
        if (blank1_q) begin
            rgb_d = 12'h000;
        end else if (win1_q) begin
            rgb_d = shade_to_rgb(rd_data_q);
        end else begin
            rgb_d = BORDER_RGB;
        end
    end

    // Framebuffer RAM: write port is free-running, read is read-first on pix_ce.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            fb_mem[lcd.lcd_addr[AW-1:0]] <= lcd.pixel_out;
        end
        if (rd_en_s) begin
            rd_data_q <= fb_mem[rd_addr_s[AW-1:0]];
        end
    end

    // Counter state and the two pipeline stages that keep sync aligned with RGB.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_q         <= 10'd0;
            v_q         <= 10'd0;
            sx_q        <= 2'd0;
            gb_x_q      <= 8'd0;
            sy_q        <= 2'd0;
            gb_y_q      <= 8'd0;
            line_base_q <= 15'd0;
            win1_q      <= 1'b0;
            blank1_q    <= 1'b1;
            hs1_q       <= 1'b1;
            vs1_q       <= 1'b1;
            rgb_q       <= 12'h000;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
        end else begin
            h_q         <= h_d;
            v_q         <= v_d;
            sx_q        <= sx_d;
            gb_x_q      <= gb_x_d;
            sy_q        <= sy_d;
            gb_y_q      <= gb_y_d;
            line_base_q <= line_base_d;
            if (pix_ce) begin
                win1_q   <= in_win_s;
                blank1_q <= blank_s;
                hs1_q    <= hs_raw_s;
                vs1_q    <= vs_raw_s;
                rgb_q    <= rgb_d;
                hs_q     <= hs1_q;
                vs_q     <= vs1_q;
            end
        end
    end

    assign lcd.vga_r       = rgb_q[11:8];
    assign lcd.vga_g       = rgb_q[7:4];
    assign lcd.vga_b       = rgb_q[3:0];
    assign lcd.vga_hs      = hs_q;
    assign lcd.vga_vs      = vs_q;
    // Held low while in reset so the undelayed origin decode cannot leak a pulse.
    assign lcd.frame_start = rst && pix_ce && origin_s;
endmodule

// File: tb/tb_lcd_fb_scanout.sv
// Directed bench: a full-geometry instance for line-level timing and row-0 content, and a
// shrunk-geometry instance for whole-frame, bottom-edge, rate, reset and collision scenarios.
module tb_lcd_fb_scanout;
`ifdef LCD_FB_DMG_GREEN_EN
    localparam logic [11:0] C0 = 12'h9B0;
    localparam logic [11:0] C1 = 12'h8A0;
    localparam logic [11:0] C2 = 12'h363;
    localparam logic [11:0] C3 = 12'h030;
`else
    localparam logic [11:0] C0 = 12'hFFF;
    localparam logic [11:0] C1 = 12'hAAA;
    localparam logic [11:0] C2 = 12'h555;
    localparam logic [11:0] C3 = 12'h000;
`endif
    // Shrunk frame: 32 ticks per line, 20 lines, 640 ticks per frame, window h 4..19 / v 2..13.
    localparam int SF = 640;

    logic clk;
    logic rst;
    logic pix_ce;
    int   ticks;
    int   ce_mode;
    int   phase;
    int   pass_cnt;
    int   chk_cnt;

    lcd_fb_scanout_if bif ();
    lcd_fb_scanout_if sif ();

    lcd_fb_scanout u_big (
        .clk    (clk),
        .rst    (rst),
        .pix_ce (pix_ce),
        .lcd    (bif)
    );

    lcd_fb_scanout #(
        .GB_W(8), .GB_H(6), .SCALE(2),
        .H_ACTIVE(24), .H_FP(2), .H_SYNC(4), .H_TOTAL(32),
        .V_ACTIVE(16), .V_FP(1), .V_SYNC(2), .V_TOTAL(20),
        .X_OFF(4), .Y_OFF(2)
    ) u_sml (
        .clk    (clk),
        .rst    (rst),
        .pix_ce (pix_ce),
        .lcd    (sif)
    );

    logic [11:0] b_rgb;
    logic [11:0] s_rgb;
    assign b_rgb = {bif.vga_r, bif.vga_g, bif.vga_b};
    assign s_rgb = {sif.vga_r, sif.vga_g, sif.vga_b};

    always #5 clk = ~clk;

    task automatic tick();
        logic ce_now;
        ce_now = pix_ce & rst;
        @(posedge clk);
        #1;
        if (!rst) ticks = 0;
        else if (ce_now) ticks = ticks + 1;
        phase  = (phase + 1) % 4;
        pix_ce = (ce_mode == 1) || (ce_mode == 2 && phase == 0);
    endtask

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        while (ticks < target && guard < 60000) begin
            tick();
            guard++;
        end
        if (ticks != target) begin
            chk_cnt++;
            $display("FAIL run_to: reached tick %0d, required %0d", ticks, target);
        end
    endtask

    task automatic write_px(input bit big, input logic [14:0] addr, input logic [1:0] sh);
        if (big) begin
            bif.lcd_write = 1'b1; bif.lcd_addr = addr; bif.pixel_out = sh;
        end else begin
            sif.lcd_write = 1'b1; sif.lcd_addr = addr; sif.pixel_out = sh;
        end
        tick();
        bif.lcd_write = 1'b0;
        sif.lcd_write = 1'b0;
    endtask

    task automatic test_reset();
        ce_mode = 1;
        repeat (3) tick();
        chk_cnt++;
        if ({b_rgb, bif.vga_hs, bif.vga_vs, bif.frame_start} !== {12'h000, 1'b1, 1'b1, 1'b0})
            $display("FAIL reset_big: got rgb=%h hs=%b vs=%b fs=%b, required 000/1/1/0",
                     b_rgb, bif.vga_hs, bif.vga_vs, bif.frame_start);
        else pass_cnt++;
        chk_cnt++;
        if ({s_rgb, sif.vga_hs, sif.vga_vs, sif.frame_start} !== {12'h000, 1'b1, 1'b1, 1'b0})
            $display("FAIL reset_sml: got rgb=%h hs=%b vs=%b fs=%b, required 000/1/1/0",
                     s_rgb, sif.vga_hs, sif.vga_vs, sif.frame_start);
        else pass_cnt++;
        ce_mode = 0;
        pix_ce  = 1'b0;
        rst     = 1'b1;
        #1;
    endtask

    task automatic load_frames();
        for (int a = 0; a < 160; a++) write_px(1'b1, 15'(a), 2'd0);
        write_px(1'b1, 15'd0, 2'd3);
        write_px(1'b1, 15'd159, 2'd1);
        write_px(1'b1, 15'd23039, 2'd2);
        write_px(1'b1, 15'd23040, 2'd3);
        for (int a = 0; a < 48; a++) write_px(1'b0, 15'(a), 2'd0);
        write_px(1'b0, 15'd0, 2'd3);
        write_px(1'b0, 15'd7, 2'd1);
        write_px(1'b0, 15'd47, 2'd2);
        write_px(1'b0, 15'd48, 2'd3);
        write_px(1'b0, 15'd64, 2'd1);
    endtask

    task automatic test_sync();
        int fs_n, fs_first, fs_second, bfs_n, bhs_n, bhs_first, shs_n, shs_first, svs_n, svs_first;
        fs_n = 0; fs_first = -1; fs_second = -1; bfs_n = 0; bhs_n = 0; bhs_first = -1;
        shs_n = 0; shs_first = -1; svs_n = 0; svs_first = -1;
        ce_mode = 1;
        pix_ce  = 1'b1;
        #1;
        for (int c = 0; c < 2 * SF; c++) begin
            if (sif.frame_start === 1'b1) begin
                fs_n++;
                if (fs_n == 1) fs_first = ticks; else fs_second = ticks;
            end
            if (bif.frame_start === 1'b1) bfs_n++;
            if (ticks < 800 && bif.vga_hs === 1'b0) begin
                if (bhs_n == 0) bhs_first = ticks;
                bhs_n++;
            end
            if (ticks < 32 && sif.vga_hs === 1'b0) begin
                if (shs_n == 0) shs_first = ticks;
                shs_n++;
            end
            if (ticks < SF && sif.vga_vs === 1'b0) begin
                if (svs_n == 0) svs_first = ticks;
                svs_n++;
            end
            tick();
        end
        chk_cnt++; if (fs_n !== 2) $display("FAIL fs_count: got %0d required 2", fs_n); else pass_cnt++;
        chk_cnt++; if (fs_first !== 0) $display("FAIL fs_first: got %0d required 0", fs_first); else pass_cnt++;
        chk_cnt++; if (fs_second !== SF) $display("FAIL fs_period: got %0d required %0d", fs_second, SF); else pass_cnt++;
        chk_cnt++; if (bfs_n !== 1) $display("FAIL big_fs_count: got %0d required 1", bfs_n); else pass_cnt++;
        chk_cnt++; if (bhs_n !== 96) $display("FAIL big_hs_width: got %0d required 96", bhs_n); else pass_cnt++;
        chk_cnt++; if (bhs_first !== 658) $display("FAIL big_hs_start: got %0d required 658", bhs_first); else pass_cnt++;
        chk_cnt++; if (shs_n !== 4) $display("FAIL sml_hs_width: got %0d required 4", shs_n); else pass_cnt++;
        chk_cnt++; if (shs_first !== 28) $display("FAIL sml_hs_start: got %0d required 28", shs_first); else pass_cnt++;
        chk_cnt++; if (svs_n !== 64) $display("FAIL sml_vs_width: got %0d required 64", svs_n); else pass_cnt++;
        chk_cnt++; if (svs_first !== 546) $display("FAIL sml_vs_start: got %0d required 546", svs_first); else pass_cnt++;
    endtask

    task automatic test_window_big();
        int          hl [8] = '{82, 83, 84, 85, 558, 559, 561, 562};
        logic [11:0] el [8] = '{C3, C3, C3, C0, C0, C1, C1, 12'h000};
        run_to(23 * 800 + 83);
        chk_cnt++;
        if (b_rgb !== 12'h000) $display("FAIL big_above_win: got %h required 000", b_rgb); else pass_cnt++;
        for (int v = 24; v <= 26; v++) begin
            for (int i = 0; i < 8; i++) begin
                run_to(v * 800 + hl[i]);
                chk_cnt++;
                if (b_rgb !== el[i])
                    $display("FAIL big_win v=%0d h=%0d: got %h required %h", v, hl[i], b_rgb, el[i]);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_window_small();
        int          vl [13] = '{1, 2, 2, 2, 2, 2, 2, 2, 3, 12, 12, 13, 14};
        int          hl [13] = '{20, 6, 7, 8, 19, 20, 21, 22, 7, 19, 20, 21, 20};
        logic [11:0] el [13] = '{12'h000, C3, C3, C0, C0, C1, C1, 12'h000, C3, C0, C2, C2, 12'h000};
        int base;
        base = (ticks / SF + 1) * SF;
        for (int i = 0; i < 13; i++) begin
            run_to(base + vl[i] * 32 + hl[i]);
            chk_cnt++;
            if (s_rgb !== el[i])
                $display("FAIL sml_win v=%0d h=%0d: got %h required %h", vl[i], hl[i], s_rgb, el[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_quarter_rate();
        int base, rel, fs_c, hs_c, c0_c, c1_c;
        fs_c = 0; hs_c = 0; c0_c = 0; c1_c = 0;
        base = (ticks / SF + 1) * SF;
        run_to(base);
        ce_mode = 2;
        phase   = 0;
        pix_ce  = 1'b1;
        #1;
        for (int c = 0; c < 600 && ticks < base + 85; c++) begin
            rel = ticks - base;
            if (rel < 32 && sif.frame_start === 1'b1) fs_c++;
            if (rel < 32 && sif.vga_hs === 1'b0) hs_c++;
            if (rel == 72 && s_rgb === C0) c0_c++;
            if (rel == 84 && s_rgb === C1) c1_c++;
            tick();
        end
        chk_cnt++; if (fs_c !== 1) $display("FAIL q_fs_cycles: got %0d required 1", fs_c); else pass_cnt++;
        chk_cnt++; if (hs_c !== 16) $display("FAIL q_hs_cycles: got %0d required 16", hs_c); else pass_cnt++;
        chk_cnt++; if (c0_c !== 4) $display("FAIL q_hold_c0: got %0d required 4", c0_c); else pass_cnt++;
        chk_cnt++; if (c1_c !== 4) $display("FAIL q_hold_c1: got %0d required 4", c1_c); else pass_cnt++;
        ce_mode = 1;
        pix_ce  = 1'b1;
        #1;
    endtask

    task automatic test_midframe_reset();
        int base;
        base = (ticks / SF + 1) * SF;
        run_to(base + 2 * 32 + 9);
        chk_cnt++;
        if (s_rgb !== C0) $display("FAIL pre_reset: got %h required %h", s_rgb, C0); else pass_cnt++;
        rst = 1'b0;
        #1;
        chk_cnt++;
        if ({s_rgb, sif.vga_hs, sif.vga_vs} !== {12'h000, 1'b1, 1'b1})
            $display("FAIL async_reset: got rgb=%h hs=%b vs=%b required 000/1/1", s_rgb, sif.vga_hs, sif.vga_vs);
        else pass_cnt++;
        repeat (2) tick();
        rst = 1'b1;
        #1;
        chk_cnt++;
        if (sif.frame_start !== 1'b1) $display("FAIL fs_after_reset: got %b required 1", sif.frame_start); else pass_cnt++;
        run_to(2 * 32 + 6);
        chk_cnt++;
        if (s_rgb !== C3) $display("FAIL fb_kept_a: got %h required %h", s_rgb, C3); else pass_cnt++;
        run_to(2 * 32 + 20);
        chk_cnt++;
        if (s_rgb !== C1) $display("FAIL fb_kept_b: got %h required %h", s_rgb, C1); else pass_cnt++;
    endtask

    task automatic test_collision();
        int base;
        base = (ticks / SF + 1) * SF;
        run_to(base + 2 * 32 + 6);
        sif.lcd_write = 1'b1; sif.lcd_addr = 15'd1; sif.pixel_out = 2'd3;
        tick();
        sif.lcd_write = 1'b0;
        run_to(base + 2 * 32 + 8);
        chk_cnt++;
        if (s_rgb !== C0) $display("FAIL read_first_old: got %h required %h", s_rgb, C0); else pass_cnt++;
        run_to(base + 2 * 32 + 9);
        chk_cnt++;
        if (s_rgb !== C3) $display("FAIL write_visible: got %h required %h", s_rgb, C3); else pass_cnt++;
    endtask

    initial begin
        clk = 1'b0; rst = 1'b0; pix_ce = 1'b0;
        ticks = 0; ce_mode = 0; phase = 0; pass_cnt = 0; chk_cnt = 0;
        bif.lcd_write = 1'b0; bif.lcd_addr = 15'd0; bif.pixel_out = 2'd0;
        sif.lcd_write = 1'b0; sif.lcd_addr = 15'd0; sif.pixel_out = 2'd0;
        test_reset();
        load_frames();
        test_sync();
        test_window_big();
        test_window_small();
        test_quarter_rate();
        test_midframe_reset();
        test_collision();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
